// File: rtl/imem_loader_pkg.sv
// Shared types and constants for the instruction-memory loader.
package loader_pkg;

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_RECV  = 3'd1,
    S_WRITE = 3'd2,
    S_CHECK = 3'd3,
    S_DONE  = 3'd4,
    S_ERR   = 3'd5
  } state_t;

  localparam int BYTES_PER_WORD = 4;

endpackage

// File: rtl/imem_loader_if.sv
// Host byte stream plus instruction-memory write port. The master modport is the loader side.
interface imem_loader_if #(parameter int ADDR_W = 10);

  logic              in_valid;
  logic [7:0]        in_data;
  logic              in_ready;
  logic              im_we;
  logic [ADDR_W-1:0] im_waddr;
  logic [31:0]       im_wdata;

  modport master (
    input  in_valid, in_data,
    output in_ready, im_we, im_waddr, im_wdata
  );

  modport slave (
    output in_valid, in_data,
    input  in_ready, im_we, im_waddr, im_wdata
  );

endinterface

// File: rtl/imem_loader_timeout.sv
// Idle-cycle counter: clears on clr, counts while en, flags when the limit is reached (limit 0 = never).
module loader_timeout #(
  parameter int TIMEOUT = 65535
) (
  input  logic CLK,
  input  logic RST,
  input  logic clr,
  input  logic en,
  output logic hit
);

  localparam int CW = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;

  logic [CW-1:0] cnt;

  assign hit = (TIMEOUT != 0) && (cnt == CW'(TIMEOUT));

  // Holding at the limit keeps the counter from wrapping past it.
  always_ff @(posedge CLK) begin
    if (RST || clr) begin
      cnt <= '0;
    end else if (en && !hit) begin
      cnt <= cnt + CW'(1);
    end
  end

endmodule

// File: rtl/imem_loader.sv
// Loads a big-endian word image from a byte stream into instruction memory and holds
// the CPU in reset until the trailing checksum byte makes the stream sum to zero.
//
// state | meaning
// IDLE  | waiting for start, CPU held in reset
// RECV  | accepting data bytes into the word buffer
// WRITE | one-cycle instruction memory write of the assembled word
// CHECK | accepting the checksum byte
// DONE  | image loaded and verified, CPU released
// ERR   | bad checksum or host timeout, CPU held in reset
module imem_loader
  import loader_pkg::*;
#(
  parameter int ADDR_W  = 10,
  parameter int TIMEOUT = 65535
) (
  input  logic              CLK,
  input  logic              RST,
  input  logic              start,
  input  logic [ADDR_W-1:0] len,
  imem_loader_if.master     bus,
  output logic              cpu_rst,
  output logic              busy,
  output logic              done,
  output logic              err
);

  state_t state, state_nx;

  logic              ready;
  logic              hs;
  logic              hit;
  logic              restart;
  logic              last_byte;
  logic              last_word;
  logic [1:0]        byte_cnt;
  logic [ADDR_W-1:0] word_cnt;
  logic [ADDR_W-1:0] len_q;
  logic [7:0]        csum;
  logic [7:0]        csum_nx;
  logic [23:0]       buf_q;
  logic [ADDR_W-1:0] waddr_q;
  logic [31:0]       wdata_q;

  assign hs        = bus.in_valid && ready;
  assign restart   = start && (state == S_IDLE || state == S_DONE || state == S_ERR);
  assign last_byte = (byte_cnt == 2'(BYTES_PER_WORD - 1));
  // len=0 latches as 0, so len_q-1 is all ones and the word counter wraps through 2^ADDR_W words.
  assign last_word = (word_cnt == len_q - ADDR_W'(1));
  assign csum_nx   = csum + bus.in_data;

  assign bus.in_ready = ready;
  assign bus.im_waddr = waddr_q;
  assign bus.im_wdata = wdata_q;

  loader_timeout #(.TIMEOUT(TIMEOUT)) u_timeout (
    .CLK (CLK),
    .RST (RST),
    .clr (hs || !ready),
    .en  (ready && !hs),
    .hit (hit)
  );

  always_ff @(posedge CLK) begin
    if (RST) begin
      state <= S_IDLE;
    end else begin
      state <= state_nx;
    end
  end

  always_comb begin
    state_nx  = state;
    ready     = 1'b0;
    bus.im_we = 1'b0;
    cpu_rst   = 1'b1;
    busy      = 1'b0;
    done      = 1'b0;
    err       = 1'b0;
    case (state)
      S_IDLE: begin
        if (start) state_nx = S_RECV;
      end
      S_RECV: begin
        ready = 1'b1;
        busy  = 1'b1;
        if (hs) begin
          if (last_byte) state_nx = S_WRITE;
        end else if (hit) begin
          state_nx = S_ERR;
        end
      end
      S_WRITE: begin
        bus.im_we = 1'b1;
        busy      = 1'b1;
        state_nx  = last_word ? S_CHECK : S_RECV;
      end
      S_CHECK: begin
        ready = 1'b1;
        busy  = 1'b1;
        if (hs) begin
          state_nx = (csum_nx == 8'd0) ? S_DONE : S_ERR;
        end else if (hit) begin
          state_nx = S_ERR;
        end
      end
      S_DONE: begin
        cpu_rst = 1'b0;
        done    = 1'b1;
        if (start) state_nx = S_RECV;
      end
      S_ERR: begin
        err = 1'b1;
        if (start) state_nx = S_RECV;
      end
      default: state_nx = S_IDLE;
    endcase
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      len_q    <= '0;
      byte_cnt <= '0;
      word_cnt <= '0;
      csum     <= '0;
      buf_q    <= '0;
      waddr_q  <= '0;
      wdata_q  <= '0;
    end else if (restart) begin
      len_q    <= len;
      byte_cnt <= '0;
      word_cnt <= '0;
      csum     <= '0;
      buf_q    <= '0;
    end else begin
      if (state == S_RECV && hs) begin
        byte_cnt <= byte_cnt + 2'd1;
        csum     <= csum_nx;
        buf_q    <= {buf_q[15:0], bus.in_data};
        if (last_byte) begin
          waddr_q <= word_cnt;
          wdata_q <= {buf_q, bus.in_data};
        end
      end
      if (state == S_WRITE) begin
        word_cnt <= word_cnt + ADDR_W'(1);
      end
    end
  end

endmodule

// File: tb/tb_imem_loader.sv
// Scoreboard bench for imem_loader: expected writes are queued as bytes are driven and
// popped by a monitor whenever im_we pulses.
module tb_imem_loader;
  import loader_pkg::*;

  localparam int ADDR_W = 10;
  localparam int TMO    = 8;

  typedef struct {
    logic [ADDR_W-1:0] addr;
    logic [31:0]       data;
  } wr_t;

  logic              CLK = 1'b0;
  logic              RST = 1'b1;
  logic              start = 1'b0;
  logic [ADDR_W-1:0] len = '0;
  logic              cpu_rst, busy, done, err;

  imem_loader_if #(.ADDR_W(ADDR_W)) bus ();

  imem_loader #(.ADDR_W(ADDR_W), .TIMEOUT(TMO)) dut (
    .CLK     (CLK),
    .RST     (RST),
    .start   (start),
    .len     (len),
    .bus     (bus),
    .cpu_rst (cpu_rst),
    .busy    (busy),
    .done    (done),
    .err     (err)
  );

  always #5 CLK = ~CLK;

  int   n_checks = 0;
  int   n_errors = 0;
  int   n_writes = 0;
  wr_t  exp_q[$];
  wr_t  mon_e;
  logic [7:0] stream[$];
  int   n_data;
  logic [7:0] basic_bytes[8] = '{8'h20, 8'h08, 8'h00, 8'h05, 8'h00, 8'h00, 8'h00, 8'h08};

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s observed=%0h expected=%0h t=%0t", tag, obs, exp, $time);
    end
  endtask

  always @(negedge CLK) begin
    if (bus.im_we === 1'b1) begin
      n_writes++;
      if (exp_q.size() == 0) begin
        check("unexpected_we", 32'd1, 32'd0);
      end else begin
        mon_e = exp_q.pop_front();
        check("we_addr", 32'(bus.im_waddr), 32'(mon_e.addr));
        check("we_data", bus.im_wdata, mon_e.data);
      end
    end
  end

  task automatic make_stream(input int n_words, input bit basic, input bit bad);
    logic [7:0] sum;
    logic [7:0] b;
    stream.delete();
    n_data = n_words * 4;
    sum = 8'd0;
    for (int i = 0; i < n_data; i++) begin
      b = basic ? basic_bytes[i] : 8'($urandom);
      stream.push_back(b);
      sum = sum + b;
    end
    b = 8'd0 - sum;
    if (bad) b = b + 8'd1;
    stream.push_back(b);
  endtask

  task automatic send_byte(input logic [7:0] b);
    bit got;
    got = 1'b0;
    @(negedge CLK);
    bus.in_valid = 1'b1;
    bus.in_data  = b;
    for (int k = 0; k < 64; k++) begin
      if (bus.in_ready === 1'b1) begin
        @(posedge CLK);
        got = 1'b1;
        break;
      end
      @(negedge CLK);
    end
    if (!got) check("handshake_timeout", 32'd0, 32'd1);
  endtask

  task automatic idle(input int n);
    @(negedge CLK);
    bus.in_valid = 1'b0;
    repeat (n) @(posedge CLK);
  endtask

  task automatic finish_stream();
    @(negedge CLK);
    bus.in_valid = 1'b0;
  endtask

  // stall: one idle cycle after each byte, eight after byte long_at.
  task automatic send_range(input int lo, input int hi, input bit stall, input int long_at);
    wr_t w;
    for (int i = lo; i < hi; i++) begin
      if (i < n_data && (i % 4) == 3) begin
        w.addr = ADDR_W'(i / 4);
        w.data = {stream[i-3], stream[i-2], stream[i-1], stream[i]};
        exp_q.push_back(w);
      end
      send_byte(stream[i]);
      if (stall) idle((i == long_at) ? 8 : 1);
    end
  endtask

  task automatic pulse_start(input int l);
    @(negedge CLK);
    start = 1'b1;
    len   = ADDR_W'(l);
    @(negedge CLK);
    start = 1'b0;
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog expired at t=%0t", $time);
    $fatal(1, "watchdog");
  end

  initial begin
    int w0;
    bus.in_valid = 1'b0;
    bus.in_data  = 8'd0;

    repeat (3) @(posedge CLK);
    @(negedge CLK);
    check("rst_cpu_rst", cpu_rst, 1);
    check("rst_in_ready", bus.in_ready, 0);
    check("rst_im_we", bus.im_we, 0);
    check("rst_im_waddr", 32'(bus.im_waddr), 0);
    check("rst_im_wdata", bus.im_wdata, 0);
    check("rst_busy", busy, 0);
    check("rst_done", done, 0);
    check("rst_err", err, 0);
    RST = 1'b0;

    // Basic load
    make_stream(2, 1'b1, 1'b0);
    pulse_start(2);
    check("basic_busy", busy, 1);
    send_range(0, 4, 1'b0, -1);
    @(negedge CLK);
    check("we_latency", bus.im_we, 1);
    send_range(4, 9, 1'b0, -1);
    finish_stream();
    check("basic_done", done, 1);
    check("basic_cpu_rst", cpu_rst, 0);
    check("basic_err", err, 0);
    check("basic_hold_addr", 32'(bus.im_waddr), 32'd1);
    check("basic_hold_data", bus.im_wdata, 32'h0000_0008);
    check("basic_drained", exp_q.size(), 0);

    // Restart from DONE with a bad checksum byte
    make_stream(2, 1'b1, 1'b1);
    pulse_start(2);
    check("restart_cpu_rst", cpu_rst, 1);
    check("restart_busy", busy, 1);
    send_range(0, 9, 1'b0, -1);
    finish_stream();
    check("badsum_err", err, 1);
    check("badsum_cpu_rst", cpu_rst, 1);
    check("badsum_done", done, 0);
    check("badsum_drained", exp_q.size(), 0);

    // Host stalls, including an 8-cycle gap right at the timeout limit
    make_stream(2, 1'b1, 1'b0);
    pulse_start(2);
    send_range(0, 9, 1'b1, 1);
    finish_stream();
    check("stall_done", done, 1);
    check("stall_err", err, 0);
    check("stall_drained", exp_q.size(), 0);

    // A 9-cycle gap times out
    make_stream(2, 1'b0, 1'b0);
    pulse_start(2);
    send_range(0, 2, 1'b0, -1);
    idle(9);
    @(negedge CLK);
    check("timeout_err", err, 1);
    check("timeout_busy", busy, 0);
    check("timeout_cpu_rst", cpu_rst, 1);

    // start during RECV is ignored
    make_stream(2, 1'b0, 1'b0);
    pulse_start(2);
    send_range(0, 2, 1'b0, -1);
    finish_stream();
    pulse_start(1);
    check("recv_start_busy", busy, 1);
    send_range(2, 9, 1'b0, -1);
    finish_stream();
    check("recv_start_done", done, 1);
    check("recv_start_drained", exp_q.size(), 0);

    // Reset after 6 bytes of a 4-word load
    make_stream(4, 1'b0, 1'b0);
    pulse_start(4);
    send_range(0, 6, 1'b0, -1);
    @(negedge CLK);
    bus.in_valid = 1'b0;
    RST = 1'b1;
    @(negedge CLK);
    RST = 1'b0;
    check("midrst_cpu_rst", cpu_rst, 1);
    check("midrst_busy", busy, 0);
    check("midrst_in_ready", bus.in_ready, 0);
    check("midrst_done", done, 0);
    repeat (10) @(negedge CLK);
    check("midrst_drained", exp_q.size(), 0);

    // len=0 loads the full 2^ADDR_W words
    w0 = n_writes;
    make_stream(1 << ADDR_W, 1'b0, 1'b0);
    pulse_start(0);
    send_range(0, n_data + 1, 1'b0, -1);
    finish_stream();
    check("wrap_done", done, 1);
    check("wrap_writes", n_writes - w0, 32'(1 << ADDR_W));
    check("wrap_drained", exp_q.size(), 0);

    repeat (3) @(negedge CLK);
    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
